turbo_encode: RTL and testbench

Rate-1/3 parallel-concatenated convolutional (turbo) encoder. It produces the systematic, parity-1 and parity-2 streams that the turbo decoder consumes. The block buffers one K-bit frame and encodes it with two identical 8-state recursive systematic convolutional (RSC) encoders. The second encoder reads the frame in quadratic-permutation-polynomial (QPP) interleaved order. Hard output bits go to the modulator/channel model that feeds the decoder testbench.

---
 rtl/turbo_enc_pkg.sv | 28 ++
 rtl/rsc_enc.sv | 35 +++
 rtl/turbo_encode.sv | 206 ++++++++++++++++++++
 tb/tb_turbo_encode.sv | 359 +++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/turbo_enc_pkg.sv
// Shared types and constants for the rate-1/3 turbo encoder.
// Optional trellis termination is enabled with the TURBO_ENC_TAIL_EN macro.
package turbo_enc_pkg;

  typedef enum logic [2:0] {
    ST_LOAD,
    ST_ENC,
    ST_TAIL1,
    ST_TAIL2,
    ST_FLUSH
  } state_t;

  // RSC state vector is {s1,s2,s3}; feedback 1+D^2+D^3, parity 1+D+D^3
  localparam logic [2:0] RSC_FB_TAPS  = 3'b011;
  localparam logic [2:0] RSC_PAR_TAPS = 3'b101;

  localparam int DEF_K  = 40;
  localparam int DEF_F1 = 3;
  localparam int DEF_F2 = 10;

  function automatic int clog2(input int n);
    int r;
    r = 0;
    for (int v = 1; v < n; v = v * 2) r = r + 1;
    return r;
  endfunction

endpackage

// File: rtl/rsc_enc.sv
// 8-state recursive systematic convolutional encoder; sys/par are combinational
// for the current state, the state advances on step. term forces a=0 (trellis flush).
module rsc_enc
  import turbo_enc_pkg::*;
(
  input  logic clk,
  input  logic rst,
  input  logic clear,
  input  logic step,
  input  logic term,
  input  logic u,
  output logic sys,
  output logic par
);

  logic [2:0] st_q;
  logic       fb;
  logic       a;

  assign fb  = ^(st_q & RSC_FB_TAPS);
  assign sys = term ? fb : u;
  assign a   = sys ^ fb;
  assign par = a ^ (^(st_q & RSC_PAR_TAPS));

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      st_q <= '0;
    end else if (clear) begin
      st_q <= '0;
    end else if (step) begin
      st_q <= {a, st_q[2:1]};
    end
  end

endmodule

// File: rtl/turbo_encode.sv
// Rate-1/3 turbo encoder: buffers one K-bit frame, encodes it with two RSCs (second in
// QPP order). TURBO_ENC_TAIL_EN adds 6 termination beats per frame.
//
// state    | meaning
// ---------+-----------------------------------------------------------
// ST_LOAD  | accept info bits into the frame buffer
// ST_ENC   | emit K systematic/parity beats
// ST_TAIL1 | 3 termination beats driving RSC1 to 000
// ST_TAIL2 | 3 termination beats driving RSC2 to 000
// ST_FLUSH | wait for the out_last handshake
module turbo_encode
  import turbo_enc_pkg::*;
#(
  parameter int K  = DEF_K,
  parameter int F1 = DEF_F1,
  parameter int F2 = DEF_F2
) (
  input  logic clk,
  input  logic rst,
  input  logic in_valid,
  output logic in_ready,
  input  logic in_bit,
  output logic out_valid,
  input  logic out_ready,
  output logic out_x,
  output logic out_y1,
  output logic out_y2,
  output logic out_tail,
  output logic out_last,
  output logic busy
);

  localparam int              AW       = clog2(K);
  localparam logic [AW-1:0]   ONE      = AW'(1);
  localparam logic [AW-1:0]   LAST_IDX = AW'(K - 1);
  localparam logic [AW-1:0]   TAIL_IDX = AW'(2);
  localparam logic [AW:0]     K_EXT    = (AW + 1)'(K);
  localparam logic [AW-1:0]   G_INIT   = AW'((F1 + F2) % K);
  localparam logic [AW-1:0]   G_STEP   = AW'((2 * F2) % K);

  state_t        state_q, state_d;
  logic [AW-1:0] cnt_q, cnt_d;
  logic [AW-1:0] pi_q, pi_d;
  logic [AW-1:0] g_q, g_d;
  logic [K-1:0]  frame_q;

  logic out_load, beat, rsc_clear;
  logic x_d, y1_d, y2_d, tail_d, last_d;
  logic sys1, sys2, par1, par2;
  logic step1, step2, term1, term2;

  logic [AW:0]   pi_sum, g_sum;
  logic [AW-1:0] pi_next, g_next;

  assign in_ready = (state_q == ST_LOAD);
  assign busy     = (state_q != ST_LOAD) || (cnt_q != '0);
  assign out_load = !out_valid || out_ready;

  // Incremental QPP: each modulo is a single compare-and-subtract of K
  assign pi_sum  = {1'b0, pi_q} + {1'b0, g_q};
  assign pi_next = (pi_sum >= K_EXT) ? AW'(pi_sum - K_EXT) : AW'(pi_sum);
  assign g_sum   = {1'b0, g_q} + {1'b0, G_STEP};
  assign g_next  = (g_sum >= K_EXT) ? AW'(g_sum - K_EXT) : AW'(g_sum);

  assign term1 = (state_q == ST_TAIL1);
  assign term2 = (state_q == ST_TAIL2);
  assign step1 = beat && ((state_q == ST_ENC) || term1);
  assign step2 = beat && ((state_q == ST_ENC) || term2);

  rsc_enc u_rsc1 (
    .clk   (clk),
    .rst   (rst),
    .clear (rsc_clear),
    .step  (step1),
    .term  (term1),
    .u     (frame_q[cnt_q]),
    .sys   (sys1),
    .par   (par1)
  );

  rsc_enc u_rsc2 (
    .clk   (clk),
    .rst   (rst),
    .clear (rsc_clear),
    .step  (step2),
    .term  (term2),
    .u     (frame_q[pi_q]),
    .sys   (sys2),
    .par   (par2)
  );

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    pi_d      = pi_q;
    g_d       = g_q;
    rsc_clear = 1'b0;
    beat      = 1'b0;
    x_d       = (state_q == ST_TAIL2) ? sys2 : sys1;
    y1_d      = par1;
    y2_d      = par2;
    tail_d    = 1'b0;
    last_d    = 1'b0;
    case (state_q)
      ST_LOAD: begin
        if (in_valid) begin
          cnt_d = cnt_q + ONE;
          if (cnt_q == LAST_IDX) begin
            state_d   = ST_ENC;
            cnt_d     = '0;
            pi_d      = '0;
            g_d       = G_INIT;
            rsc_clear = 1'b1;
          end
        end
      end
      ST_ENC: begin
        if (out_load) begin
          beat  = 1'b1;
          cnt_d = cnt_q + ONE;
          pi_d  = pi_next;
          g_d   = g_next;
          if (cnt_q == LAST_IDX) begin
            cnt_d = '0;
`ifdef TURBO_ENC_TAIL_EN
            state_d = ST_TAIL1;
`else
            state_d = ST_FLUSH;
            last_d  = 1'b1;
`endif
          end
        end
      end
`ifdef TURBO_ENC_TAIL_EN
      ST_TAIL1: begin
        y2_d   = 1'b0;
        tail_d = 1'b1;
        if (out_load) begin
          beat  = 1'b1;
          cnt_d = cnt_q + ONE;
          if (cnt_q == TAIL_IDX) begin
            cnt_d   = '0;
            state_d = ST_TAIL2;
          end
        end
      end
      ST_TAIL2: begin
        y1_d   = 1'b0;
        tail_d = 1'b1;
        if (out_load) begin
          beat  = 1'b1;
          cnt_d = cnt_q + ONE;
          if (cnt_q == TAIL_IDX) begin
            cnt_d   = '0;
            last_d  = 1'b1;
            state_d = ST_FLUSH;
          end
        end
      end
`endif
      ST_FLUSH: begin
        if (out_valid && out_ready) begin
          state_d = ST_LOAD;
          cnt_d   = '0;
        end
      end
      default: state_d = ST_LOAD;
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q   <= ST_LOAD;
      cnt_q     <= '0;
      pi_q      <= '0;
      g_q       <= '0;
      out_valid <= 1'b0;
      out_x     <= 1'b0;
      out_y1    <= 1'b0;
      out_y2    <= 1'b0;
      out_tail  <= 1'b0;
      out_last  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      pi_q    <= pi_d;
      g_q     <= g_d;
      if (out_load) begin
        out_valid <= beat;
        if (beat) begin
          out_x    <= x_d;
          out_y1   <= y1_d;
          out_y2   <= y2_d;
          out_tail <= tail_d;
          out_last <= last_d;
        end
      end
    end
  end

  // Frame buffer contents are don't-care after reset, so no reset here
  always_ff @(posedge clk) begin
    if (in_ready && in_valid) frame_q[cnt_q] <= in_bit;
  end

endmodule

// File: tb/tb_turbo_encode.sv
// Self-checking bench for turbo_encode: random frames against a recurrence-based
// reference model, with backpressure, latency and mid-frame reset scenarios.
module tb_turbo_encode;

  localparam int K  = 40;
  localparam int F1 = 3;
  localparam int F2 = 10;
`ifdef TURBO_ENC_TAIL_EN
  localparam int NB = K + 6;
`else
  localparam int NB = K;
`endif

  logic clk = 1'b0;
  logic rst = 1'b0;
  logic in_valid = 1'b0;
  logic in_bit = 1'b0;
  logic out_ready = 1'b0;
  logic in_ready, out_valid, out_x, out_y1, out_y2, out_tail, out_last, busy;
  logic [4:0] out_vec;

  turbo_encode #(.K(K), .F1(F1), .F2(F2)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .in_bit    (in_bit),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_x     (out_x),
    .out_y1    (out_y1),
    .out_y2    (out_y2),
    .out_tail  (out_tail),
    .out_last  (out_last),
    .busy      (busy)
  );

  always #5 clk = ~clk;

  assign out_vec = {out_x, out_y1, out_y2, out_tail, out_last};

  int errors = 0;
  int checks = 0;

  logic       frame_bits[K];
  logic [4:0] exp_beat[NB];   // {x, y1, y2, tail, last}
  logic [4:0] cap_beat[1024];
  int         cap_cnt = 0;
  logic       in_flight = 1'b0;
  logic       stall_prev = 1'b0;
  logic [4:0] held = '0;

  // Beat capture, stall stability and in_ready-hold monitor
  always @(negedge clk) begin
    if (!rst) begin
      stall_prev = 1'b0;
    end else begin
      if (stall_prev) begin
        checks++;
        if (out_valid !== 1'b1 || out_vec !== held) begin
          errors++;
          $display("FAIL stall_hold: valid=%b beat=%b required valid=1 beat=%b", out_valid, out_vec, held);
        end
      end
      if (in_flight) begin
        checks++;
        if (in_ready !== 1'b0) begin
          errors++;
          $display("FAIL in_ready_hold: in_ready=%b required 0 before out_last handshake", in_ready);
        end
      end
      if (out_valid && out_ready) begin
        if (cap_cnt < 1024) cap_beat[cap_cnt] = out_vec;
        cap_cnt++;
        if (out_last) in_flight = 1'b0;
      end
      stall_prev = out_valid && !out_ready;
      held       = out_vec;
    end
  end

  // Reference model: a[n] is the RSC feedback sequence, s1=a[n-1], s2=a[n-2], s3=a[n-3]
  task automatic build_expected();
    logic a1[K + 6];
    logic a2[K + 6];
    logic u, p;
    int   j;
    for (int n = 0; n < K + 6; n++) begin
      a1[n] = 1'b0;
      a2[n] = 1'b0;
    end
    for (int i = 0; i < K; i++) begin
      j = i + 3;
      u = frame_bits[i];
      a1[j] = u ^ a1[j-2] ^ a1[j-3];
      p = a1[j] ^ a1[j-1] ^ a1[j-3];
      exp_beat[i] = {u, p, 1'b0, 1'b0, 1'b0};
      u = frame_bits[(F1 * i + F2 * i * i) % K];
      a2[j] = u ^ a2[j-2] ^ a2[j-3];
      exp_beat[i][2] = a2[j] ^ a2[j-1] ^ a2[j-3];
    end
`ifdef TURBO_ENC_TAIL_EN
    for (int t = 0; t < 3; t++) begin
      j = K + 3 + t;
      u = a1[j-2] ^ a1[j-3];
      a1[j] = 1'b0;
      p = a1[j-1] ^ a1[j-3];
      exp_beat[K + t] = {u, p, 1'b0, 1'b1, 1'b0};
      u = a2[j-2] ^ a2[j-3];
      a2[j] = 1'b0;
      p = a2[j-1] ^ a2[j-3];
      exp_beat[K + 3 + t] = {u, 1'b0, p, 1'b1, 1'b0};
    end
`endif
    exp_beat[NB-1][0] = 1'b1;
  endtask

  task automatic random_frame();
    for (int i = 0; i < K; i++) frame_bits[i] = 1'($urandom_range(0, 1));
  endtask

  // Starts and ends at #1 after a rising edge; in_valid left low
  task automatic load_frame(input bit gaps, input int nbits);
    for (int i = 0; i < nbits; i++) begin
      if (gaps) begin
        repeat ($urandom_range(0, 2)) begin
          in_valid = 1'b0;
          in_bit   = 1'($urandom_range(0, 1));
          @(posedge clk); #1;
        end
      end
      checks++;
      if (in_ready !== 1'b1) begin
        errors++;
        $display("FAIL load_ready: bit %0d in_ready=%b required 1", i, in_ready);
      end
      in_valid = 1'b1;
      in_bit   = frame_bits[i];
      @(posedge clk); #1;
    end
    in_valid = 1'b0;
    if (nbits == K) in_flight = 1'b1;
  endtask

  task automatic collect(input bit bp, input int nbeats);
    int guard;
    guard = 0;
    while (cap_cnt < nbeats && guard < 4000) begin
      out_ready = bp ? ($urandom_range(0, 3) != 0) : 1'b1;
      in_valid  = 1'($urandom_range(0, 1));
      in_bit    = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
      guard++;
    end
    in_valid = 1'b0;
    checks++;
    if (cap_cnt < nbeats) begin
      errors++;
      $display("FAIL collect_timeout: got %0d beats required %0d", cap_cnt, nbeats);
    end
  endtask

  task automatic run_frame(input string tag, input bit gaps, input bit bp);
    build_expected();
    cap_cnt = 0;
    load_frame(gaps, K);
    collect(bp, NB);
    out_ready = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    checks++;
    if (cap_cnt !== NB) begin
      errors++;
      $display("FAIL %s_count: beats=%0d required %0d", tag, cap_cnt, NB);
    end
    checks++;
    if ({in_ready, busy, out_valid} !== 3'b100) begin
      errors++;
      $display("FAIL %s_idle: in_ready/busy/valid=%b required 100", tag, {in_ready, busy, out_valid});
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (cap_beat[i] !== exp_beat[i]) begin
        errors++;
        $display("FAIL %s_beat: beat %0d {x,y1,y2,tail,last}=%b required %b", tag, i, cap_beat[i], exp_beat[i]);
      end
    end
  endtask

  task automatic test_reset();
    #12;
    checks++;
    if ({in_ready, out_valid, out_vec, busy} !== 8'b1_0_00000_0) begin
      errors++;
      $display("FAIL reset_values: {in_ready,valid,x,y1,y2,tail,last,busy}=%b required 10000000", {in_ready, out_valid, out_vec, busy});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    checks++;
    if ({in_ready, out_valid, busy} !== 3'b100) begin
      errors++;
      $display("FAIL reset_release: {in_ready,valid,busy}=%b required 100", {in_ready, out_valid, busy});
    end
  endtask

  task automatic test_zero_frame();
    int ntail, last_at;
    for (int i = 0; i < K; i++) frame_bits[i] = 1'b0;
    run_frame("zero", 0, 0);
    ntail = 0;
    last_at = -1;
    for (int i = 0; i < NB; i++) begin
      if (cap_beat[i][1]) ntail++;
      if (cap_beat[i][0]) last_at = (last_at == -1) ? i : -2;
    end
    checks++;
    if (ntail !== NB - K || last_at !== NB - 1) begin
      errors++;
      $display("FAIL zero_tail_last: tail beats=%0d last at=%0d required %0d and %0d", ntail, last_at, NB - K, NB - 1);
    end
  endtask

  task automatic test_impulse0();
    for (int i = 0; i < K; i++) frame_bits[i] = 1'b0;
    frame_bits[0] = 1'b1;
    run_frame("impulse0", 0, 0);
    checks++;
    if ({cap_beat[0][3], cap_beat[1][3], cap_beat[2][3], cap_beat[3][3], cap_beat[4][3]} !== 5'b11110) begin
      errors++;
      $display("FAIL impulse0_y1: y1[0..4]=%b required 11110",
               {cap_beat[0][3], cap_beat[1][3], cap_beat[2][3], cap_beat[3][3], cap_beat[4][3]});
    end
    checks++;
    if (cap_beat[0][2] !== 1'b1) begin
      errors++;
      $display("FAIL impulse0_y2: y2[0]=%b required 1", cap_beat[0][2]);
    end
  endtask

  task automatic test_impulse13();
    for (int i = 0; i < K; i++) frame_bits[i] = 1'b0;
    frame_bits[13] = 1'b1;
    run_frame("impulse13", 1, 0);
    checks++;
    if ({cap_beat[0][2], cap_beat[1][2]} !== 2'b01) begin
      errors++;
      $display("FAIL impulse13_y2: y2[0],y2[1]=%b required 01", {cap_beat[0][2], cap_beat[1][2]});
    end
  endtask

  task automatic test_latency();
    int vcnt;
    random_frame();
    build_expected();
    cap_cnt   = 0;
    out_ready = 1'b1;
    load_frame(0, K);
    checks++;
    if (out_valid !== 1'b0) begin
      errors++;
      $display("FAIL latency_bubble: out_valid=%b required 0 right after last input", out_valid);
    end
    vcnt = 0;
    for (int i = 0; i < NB; i++) begin
      @(posedge clk); #1;
      if (out_valid === 1'b1) vcnt++;
    end
    checks++;
    if (vcnt !== NB) begin
      errors++;
      $display("FAIL latency_stream: valid cycles=%0d required %0d", vcnt, NB);
    end
    @(posedge clk); #1;
    checks++;
    if ({out_valid, in_ready} !== 2'b01) begin
      errors++;
      $display("FAIL latency_return: {valid,in_ready}=%b required 01", {out_valid, in_ready});
    end
    for (int i = 0; i < NB; i++) begin
      checks++;
      if (cap_beat[i] !== exp_beat[i]) begin
        errors++;
        $display("FAIL latency_beat: beat %0d got %b required %b", i, cap_beat[i], exp_beat[i]);
      end
    end
  endtask

  task automatic test_random();
    for (int f = 0; f < 3; f++) begin
      random_frame();
      run_frame("random", 1, 0);
    end
  endtask

  task automatic test_backpressure();
    for (int f = 0; f < 3; f++) begin
      random_frame();
      run_frame("backpressure", 1, 1);
    end
  endtask

  task automatic test_abort_load();
    random_frame();
    cap_cnt = 0;
    load_frame(0, 20);
    checks++;
    if (busy !== 1'b1) begin
      errors++;
      $display("FAIL abort_load_busy: busy=%b required 1 mid-load", busy);
    end
    rst = 1'b0;
    in_flight = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_vec, busy} !== 8'b1_0_00000_0) begin
      errors++;
      $display("FAIL abort_load_reset: outputs=%b required 10000000", {in_ready, out_valid, out_vec, busy});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    random_frame();
    run_frame("after_abort_load", 0, 0);
  endtask

  task automatic test_abort_enc();
    random_frame();
    build_expected();
    cap_cnt = 0;
    load_frame(0, K);
    collect(0, 10);
    rst = 1'b0;
    in_flight = 1'b0;
    #1;
    checks++;
    if ({in_ready, out_valid, out_vec, busy} !== 8'b1_0_00000_0) begin
      errors++;
      $display("FAIL abort_enc_reset: outputs=%b required 10000000", {in_ready, out_valid, out_vec, busy});
    end
    @(posedge clk); #1;
    rst = 1'b1;
    random_frame();
    run_frame("after_abort_enc", 1, 1);
  endtask

  initial begin
    test_reset();
    test_zero_frame();
    test_impulse0();
    test_impulse13();
    test_latency();
    test_random();
    test_backpressure();
    test_abort_load();
    test_abort_enc();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
